// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// decoded instruction classes and ALU operation selects.
package riscv_pkg;

    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } cls_t;

    function automatic cls_t decode_cls(logic [6:0] op);
        cls_t c;
        case (op)
            OP_RTYPE: c = CLS_RTYPE;
            OP_ITYPE: c = CLS_ITYPE;
            OP_LOAD:  c = CLS_LOAD;
            OP_STORE: c = CLS_STORE;
            OP_BEQ:   c = CLS_BRANCH;
            default:  c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/perf_counters.sv
// Busy-cycle and retired-instruction counters for the multi-cycle sequencer.
// Only instantiated when PERF_CNT_EN is defined.
module perf_counters
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             busy,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer sharing one memory port between fetch and load/store.
// Define PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counter outputs.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [6:0]       opcode,
    input  logic             funct3_0,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             pc_src,
    output logic             reg_wr,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             busy
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    logic   illegal_q, illegal_d;

    logic       req_s, we_s, addr_sel_s, ir_wr_s, pc_wr_s, pc_src_s;
    logic       reg_wr_s, alu_src_s, mem_to_reg_s;
    logic [1:0] alu_op_s;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= FETCH;
            cls_q     <= CLS_RTYPE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        illegal_d    = illegal_q;
        req_s        = 1'b0;
        we_s         = 1'b0;
        addr_sel_s   = 1'b0;
        ir_wr_s      = 1'b0;
        pc_wr_s      = 1'b0;
        pc_src_s     = 1'b0;
        reg_wr_s     = 1'b0;
        alu_src_s    = 1'b0;
        alu_op_s     = ALU_ADD;
        mem_to_reg_s = 1'b0;

        case (state_q)
            FETCH: begin
                req_s = 1'b1;
                if (mem_ready) begin
                    ir_wr_s = 1'b1;
                    pc_wr_s = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                cls_d = decode_cls(opcode);
                if (cls_d == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = HALT_ON_ILLEGAL ? HALT : FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cls_q)
                    CLS_RTYPE: begin
                        alu_op_s = ALU_FUNCT;
                        state_d  = WB;
                    end
                    CLS_ITYPE: begin
                        alu_src_s = 1'b1;
                        alu_op_s  = ALU_FUNCT;
                        state_d   = WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_s = 1'b1;
                        state_d   = MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_s = ALU_SUB;
                        pc_src_s = 1'b1;
                        pc_wr_s  = zero ^ funct3_0;
                        state_d  = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                // Address and direction held steady until the access completes.
                req_s      = 1'b1;
                addr_sel_s = 1'b1;
                alu_src_s  = 1'b1;
                we_s       = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    state_d = (cls_q == CLS_STORE) ? FETCH : WB;
                end
            end
            WB: begin
                reg_wr_s     = 1'b1;
                mem_to_reg_s = (cls_q == CLS_LOAD);
                state_d      = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Gate with n_rst so no strobe escapes while reset is held.
    assign mem_req    = n_rst & req_s;
    assign mem_we     = n_rst & we_s;
    assign addr_sel   = n_rst & addr_sel_s;
    assign ir_wr      = n_rst & ir_wr_s;
    assign pc_wr      = n_rst & pc_wr_s;
    assign pc_src     = n_rst & pc_src_s;
    assign reg_wr     = n_rst & reg_wr_s;
    assign alu_src    = n_rst & alu_src_s;
    assign alu_op     = n_rst ? alu_op_s : 2'b00;
    assign mem_to_reg = n_rst & mem_to_reg_s;
    assign illegal    = n_rst & illegal_q;
    assign busy       = n_rst & (state_q != HALT);

`ifdef PERF_CNT_EN
    logic retire;
    assign retire = (state_q == WB)
                  | ((state_q == MEM) & mem_ready & (cls_q == CLS_STORE))
                  | ((state_q == EXEC) & (cls_q == CLS_BRANCH));

    perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .n_rst       (n_rst),
        .busy        (busy),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
